pipeline_boot_monitor: RTL and testbench

Synthesizable load-and-measure controller for the RISC-V pipeline core. Streams a DEPTH-word program image into the core's instruction-load port, using start/address/instruction. It then releases the core, counts cycles and NUM_EVT performance events such as flush and branch, and stops on the core's completion flag or on a cycle timeout. Counters are read back through a registered select port. The block sits between the program source and the pipeline top.

---
 rtl/pipeline_boot_monitor_pkg.sv | 20 ++
 rtl/pipeline_boot_monitor_sat_counter.sv | 39 +++
 rtl/pipeline_boot_monitor.sv | 170 +++++++++++++++++
 tb/tb_pipeline_boot_monitor.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_boot_monitor_pkg.sv
// Shared definitions for the pipeline boot monitor.
//   state_e     : controller state (IDLE, LOAD, RUN, DONE, TOUT)
//   CSEL_CYCLE  : counter-select value / counter slot of the cycle counter
//   EVT_FLUSH   : event strobe index of the core's flush signal
//   EVT_BRANCH  : event strobe index of the core's branch_E signal
package pipeline_boot_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    TOUT = 3'd4
  } state_e;

  localparam int CSEL_CYCLE = 0;
  localparam int EVT_FLUSH  = 0;
  localparam int EVT_BRANCH = 1;

endpackage

// File: rtl/pipeline_boot_monitor_sat_counter.sv
// Saturating up-counter used for the cycle and event counters.
//   clk : clock, rising edge
//   rst : asynchronous reset, active-high (clears the count)
//   clr : synchronous clear, has priority over en
//   en  : count enable; the count sticks at all-ones instead of wrapping
//   q   : current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en && (q_q != '1)) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipeline_boot_monitor.sv
// Load-and-measure controller for the RISC-V pipeline core.
// Streams DEPTH program words into the core's load port, releases the core,
// then counts run cycles and NUM_EVT event strobes until the core signals
// completion or the cycle budget MAX_CYCLES runs out.
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   go              : launch pulse, honoured in IDLE / DONE / TOUT only
//   ld_valid/ready  : program word handshake, ld_data is the word
//   start           : core load mode (1 = loading, core held)
//   address         : word index presented to the core
//   instruction     : word presented to the core
//   evt             : per-cycle event strobes from the core
//   done_in         : core completion flag
//   cnt_sel         : 0 = cycle count, k = event k-1, otherwise reads 0
//   cnt_rdata       : selected counter, one cycle after cnt_sel
//   busy/finished/timed_out : state flags (LOAD|RUN, DONE|TOUT, TOUT)
module pipeline_boot_monitor
  import pipeline_boot_monitor_pkg::*;
#(
  parameter int DEPTH      = 100,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_EVT    = 2,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           go,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  input  logic [DATA_W-1:0]              ld_data,
  output logic                           start,
  output logic [ADDR_W-1:0]              address,
  output logic [DATA_W-1:0]              instruction,
  input  logic [NUM_EVT-1:0]             evt,
  input  logic                           done_in,
  input  logic [$clog2(NUM_EVT+1)-1:0]   cnt_sel,
  output logic [CNT_W-1:0]               cnt_rdata,
  output logic                           busy,
  output logic                           finished,
  output logic                           timed_out
);

  localparam int SEL_W = $clog2(NUM_EVT + 1);
  // One extra index value marks "last word accepted, still being presented".
  localparam int IDX_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0] IDX_END    = IDX_W'(DEPTH);
  localparam logic [CNT_W-1:0] CYC_LAST   = CNT_W'(MAX_CYCLES - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                start_q, start_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   instruction_q, instruction_d;
  logic                busy_q, busy_d;
  logic                finished_q, finished_d;
  logic                timed_out_q, timed_out_d;
  logic [CNT_W-1:0]    cnt_rdata_q, cnt_rdata_d;

  logic                launch;
  logic                run;
  logic [CNT_W-1:0]    cnt [NUM_EVT+1];

  assign launch = go && ((state_q == IDLE) || (state_q == DONE) || (state_q == TOUT));
  assign run    = (state_q == RUN);

  // Ready drops once the last word has been taken, while it is still shown.
  assign ld_ready = (state_q == LOAD) && (idx_q != IDX_END);

  // Slot CSEL_CYCLE counts every RUN cycle; the others count event strobes.
  for (genvar gi = 0; gi <= NUM_EVT; gi++) begin : g_cnt
    logic en;
    if (gi == CSEL_CYCLE) begin : g_cyc
      assign en = run;
    end else begin : g_evt
      assign en = run && evt[gi-1];
    end
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (launch),
      .en  (en),
      .q   (cnt[gi])
    );
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    start_d       = start_q;
    address_d     = address_q;
    instruction_d = instruction_q;

    case (state_q)
      IDLE, DONE, TOUT: begin
        if (go) begin
          state_d = LOAD;
          idx_d   = '0;
          start_d = 1'b1;
        end
      end
      LOAD: begin
        if (idx_q == IDX_END) begin
          // Last word has had its presentation cycle: release the core.
          state_d = RUN;
          start_d = 1'b0;
        end else if (ld_valid) begin
          address_d     = ADDR_W'(idx_q);
          instruction_d = ld_data;
          idx_d         = idx_q + 1'b1;
        end
      end
      RUN: begin
        // Counters still take this cycle's increments; done wins a tie.
        if (done_in) begin
          state_d = DONE;
        end else if (cnt[CSEL_CYCLE] == CYC_LAST) begin
          state_d = TOUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d == LOAD) || (state_d == RUN);
    finished_d  = (state_d == DONE) || (state_d == TOUT);
    timed_out_d = (state_d == TOUT);

    cnt_rdata_d = '0;
    for (int i = 0; i <= NUM_EVT; i++) begin
      if (cnt_sel == SEL_W'(i)) begin
        cnt_rdata_d = cnt[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      start_q       <= 1'b0;
      address_q     <= '0;
      instruction_q <= '0;
      busy_q        <= 1'b0;
      finished_q    <= 1'b0;
      timed_out_q   <= 1'b0;
      cnt_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      start_q       <= start_d;
      address_q     <= address_d;
      instruction_q <= instruction_d;
      busy_q        <= busy_d;
      finished_q    <= finished_d;
      timed_out_q   <= timed_out_d;
      cnt_rdata_q   <= cnt_rdata_d;
    end
  end

  assign start       = start_q;
  assign address     = address_q;
  assign instruction = instruction_q;
  assign busy        = busy_q;
  assign finished    = finished_q;
  assign timed_out   = timed_out_q;
  assign cnt_rdata   = cnt_rdata_q;

endmodule

// File: tb/tb_pipeline_boot_monitor.sv
module tb_pipeline_boot_monitor;
  import pipeline_boot_monitor_pkg::*;

  localparam int DEPTH   = 4;
  localparam int NUM_EVT = 2;
  localparam int MAXC    = 50;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;
  localparam int P_DONE = 3;
  localparam int P_TOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = '0;
  logic [1:0]  evt = '0;
  logic        done_in = 1'b0;
  logic [1:0]  cnt_sel = '0;
  logic        ld_ready, start, busy, finished, timed_out;
  logic [31:0] address, instruction, cnt_rdata;

  // Narrow-counter instance for the saturation / out-of-range readout case.
  logic        go_s = 1'b0;
  logic [1:0]  evt_s = '0;
  logic [1:0]  sel_s = '0;
  logic        ld_ready_s, start_s, busy_s, finished_s, timed_out_s;
  logic [31:0] address_s, instruction_s;
  logic [3:0]  cnt_rdata_s;

  logic        clr_sc = 1'b0;
  logic        en_sc = 1'b0;
  logic [3:0]  q_sc;

  int total = 0;
  int bad   = 0;

  logic [31:0] img [4] = '{32'h00500093, 32'h00100113, 32'h002081B3, 32'h00000013};

  always #5 clk = ~clk;

  pipeline_boot_monitor #(
    .DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .NUM_EVT(NUM_EVT),
    .CNT_W(32), .MAX_CYCLES(MAXC)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .start(start), .address(address), .instruction(instruction),
    .evt(evt), .done_in(done_in), .cnt_sel(cnt_sel), .cnt_rdata(cnt_rdata),
    .busy(busy), .finished(finished), .timed_out(timed_out)
  );

  pipeline_boot_monitor #(
    .DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .NUM_EVT(NUM_EVT),
    .CNT_W(4), .MAX_CYCLES(15)
  ) dut_s (
    .clk(clk), .rst(rst), .go(go_s), .ld_valid(ld_valid), .ld_ready(ld_ready_s),
    .ld_data(ld_data), .start(start_s), .address(address_s), .instruction(instruction_s),
    .evt(evt_s), .done_in(1'b0), .cnt_sel(sel_s), .cnt_rdata(cnt_rdata_s),
    .busy(busy_s), .finished(finished_s), .timed_out(timed_out_s)
  );

  sat_counter #(.W(4)) u_sc (
    .clk(clk), .rst(rst), .clr(clr_sc), .en(en_sc), .q(q_sc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic longint sat32(input longint v);
    longint lim;
    lim = (longint'(1) << 32) - 1;
    return (v > lim) ? lim : v;
  endfunction

  // ---------------- behavioural model of the main instance ----------------
  int          ph = P_IDLE;
  int          m_idx = 0;
  bit          m_last = 0;
  bit          m_start = 0;
  longint      m_cyc = 0;
  longint      m_ev [NUM_EVT] = '{0, 0};
  logic [31:0] m_addr = '0;
  logic [31:0] m_instr = '0;
  longint      m_rdata = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        ph = P_IDLE; m_idx = 0; m_last = 0; m_start = 0;
        m_cyc = 0; m_ev = '{0, 0}; m_addr = '0; m_instr = '0; m_rdata = 0;
      end else begin
        int s;
        s = int'(cnt_sel);
        if (s == CSEL_CYCLE) m_rdata = m_cyc;
        else if (s <= NUM_EVT) m_rdata = m_ev[s-1];
        else m_rdata = 0;
        case (ph)
          P_IDLE, P_DONE, P_TOUT: begin
            if (go) begin
              ph = P_LOAD; m_idx = 0; m_last = 0; m_start = 1;
              m_cyc = 0; m_ev = '{0, 0};
            end
          end
          P_LOAD: begin
            if (m_last) begin
              ph = P_RUN; m_start = 0;
            end else if (ld_valid) begin
              m_addr = m_idx; m_instr = ld_data; m_idx++;
              m_last = (m_idx == DEPTH);
            end
          end
          default: begin
            m_cyc = sat32(m_cyc + 1);
            for (int i = 0; i < NUM_EVT; i++)
              if (evt[i]) m_ev[i] = sat32(m_ev[i] + 1);
            if (done_in) ph = P_DONE;
            else if (m_cyc >= MAXC) ph = P_TOUT;
          end
        endcase
      end
      @(negedge clk);
      chk("model.ld_ready", ld_ready, (ph == P_LOAD) && !m_last);
      chk("model.start", start, m_start);
      chk("model.address", address, m_addr);
      chk("model.instruction", instruction, m_instr);
      chk("model.busy", busy, (ph == P_LOAD) || (ph == P_RUN));
      chk("model.finished", finished, (ph == P_DONE) || (ph == P_TOUT));
      chk("model.timed_out", timed_out, ph == P_TOUT);
      chk("model.cnt_rdata", cnt_rdata, m_rdata);
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic launch_main();
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
  endtask

  task automatic stream(input int gap_after, input bit check);
    for (int w = 0; w < DEPTH; w++) begin
      ld_valid = 1'b1; ld_data = img[w];
      @(negedge clk);
      ld_valid = 1'b0;
      if (check) begin
        chk("load.address", address, w);
        chk("load.instruction", instruction, img[w]);
        chk("load.start", start, 1);
        chk("load.busy", busy, 1);
      end
      if (w == gap_after) begin
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          if (check) begin
            chk("gap.address", address, w);
            chk("gap.start", start, 1);
            chk("gap.ld_ready", ld_ready, 1);
          end
        end
      end
    end
    if (check) chk("last.ld_ready", ld_ready, 0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("reset.start", start, 0);
    chk("reset.busy", busy, 0);
    chk("reset.finished", finished, 0);
    chk("reset.cnt_rdata", cnt_rdata, 0);
    rst = 1'b0;

    // Back-to-back load, then no completion -> timeout after 50 cycles.
    launch_main();
    stream(-1, 1'b1);
    @(negedge clk);
    chk("release.start", start, 0);
    chk("release.busy", busy, 1);
    n = 0;
    while (!timed_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tout.run_cycles", n, MAXC);
    chk("tout.timed_out", timed_out, 1);
    chk("tout.finished", finished, 1);
    cnt_sel = 2'(CSEL_CYCLE);
    evt = 2'b11;
    @(negedge clk);
    chk("tout.cycles", cnt_rdata, 50);
    repeat (3) @(negedge clk);
    chk("tout.frozen", cnt_rdata, 50);
    cnt_sel = 2'(EVT_FLUSH + 1);
    @(negedge clk);
    chk("tout.flush", cnt_rdata, 0);
    evt = 2'b00;
    cnt_sel = 2'(CSEL_CYCLE);

    // Reload with a 3-cycle gap after word 1; counters restart from zero.
    launch_main();
    stream(1, 1'b1);
    chk("relaunch.cycles", cnt_rdata, 0);
    @(negedge clk);
    chk("release2.start", start, 0);

    // Run with 5 flush, 12 branch, done on cycle 40.
    for (int c = 1; c <= 40; c++) begin
      evt[EVT_FLUSH]  = (c == 3 || c == 10 || c == 17 || c == 25 || c == 40);
      evt[EVT_BRANCH] = (c >= 7) && (c % 3 == 1);
      done_in = (c == 40);
      @(negedge clk);
    end
    evt = 2'b00; done_in = 1'b0;
    chk("done.finished", finished, 1);
    chk("done.timed_out", timed_out, 0);
    cnt_sel = 2'd0; @(negedge clk); chk("done.cycles", cnt_rdata, 40);
    cnt_sel = 2'd1; @(negedge clk); chk("done.flush", cnt_rdata, 5);
    cnt_sel = 2'd2; @(negedge clk); chk("done.branch", cnt_rdata, 12);
    cnt_sel = 2'd3; @(negedge clk); chk("done.sel_oob", cnt_rdata, 0);
    cnt_sel = 2'd0;

    // Asynchronous reset mid-load at address 2.
    launch_main();
    for (int w = 0; w < 3; w++) begin
      ld_valid = 1'b1; ld_data = img[w];
      @(negedge clk);
      ld_valid = 1'b0;
    end
    chk("midload.address", address, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst.start", start, 0);
    chk("arst.address", address, 0);
    chk("arst.instruction", instruction, 0);
    chk("arst.ld_ready", ld_ready, 0);
    chk("arst.busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    launch_main();
    stream(-1, 1'b1);

    // Narrow instance: hold flush high for 30 cycles after release.
    @(negedge clk); go_s = 1'b1;
    @(negedge clk); go_s = 1'b0;
    stream(-1, 1'b0);
    @(negedge clk);
    evt_s = 2'b01; en_sc = 1'b1;
    repeat (30) @(negedge clk);
    evt_s = 2'b00; en_sc = 1'b0;
    chk("narrow.timed_out", timed_out_s, 1);
    sel_s = 2'd1; @(negedge clk); chk("narrow.flush_sat", cnt_rdata_s, 15);
    sel_s = 2'd3; @(negedge clk); chk("narrow.sel_oob", cnt_rdata_s, 0);
    sel_s = 2'd0; @(negedge clk); chk("narrow.cycles", cnt_rdata_s, 15);
    chk("satcnt.hold", q_sc, 15);
    clr_sc = 1'b1; @(negedge clk); clr_sc = 1'b0;
    chk("satcnt.clr", q_sc, 0);

    repeat (60) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
